// File: rtl/alu_ctrl_stage_pkg.sv
// ALU-control codes, field encodings and the decoded-entry bundle
// shared by the ALU-control stage and its decoder.
package alu_ctrl_stage_pkg;

  localparam int kALU_OP_SEL_WIDTH     = 5;
  localparam int kALU_BRANCH_SEL_WIDTH = 3;

  localparam logic [4:0] kSAIL_ALUCTL_ILLEGAL = 5'd0;
  localparam logic [4:0] kSAIL_ALUCTL_ADD     = 5'd1;
  localparam logic [4:0] kSAIL_ALUCTL_SUB     = 5'd2;
  localparam logic [4:0] kSAIL_ALUCTL_SLL     = 5'd3;
  localparam logic [4:0] kSAIL_ALUCTL_SLT     = 5'd4;
  localparam logic [4:0] kSAIL_ALUCTL_XOR     = 5'd5;
  localparam logic [4:0] kSAIL_ALUCTL_SRL     = 5'd6;
  localparam logic [4:0] kSAIL_ALUCTL_SRA     = 5'd7;
  localparam logic [4:0] kSAIL_ALUCTL_OR      = 5'd8;
  localparam logic [4:0] kSAIL_ALUCTL_AND     = 5'd9;
  localparam logic [4:0] kSAIL_ALUCTL_SLTU    = 5'd10;
  localparam logic [4:0] kSAIL_ALUCTL_MUL     = 5'd11;
  localparam logic [4:0] kSAIL_ALUCTL_MULH    = 5'd12;
  localparam logic [4:0] kSAIL_ALUCTL_MULHSU  = 5'd13;
  localparam logic [4:0] kSAIL_ALUCTL_MULHU   = 5'd14;
  localparam logic [4:0] kSAIL_ALUCTL_DIV     = 5'd15;
  localparam logic [4:0] kSAIL_ALUCTL_DIVU    = 5'd16;
  localparam logic [4:0] kSAIL_ALUCTL_REM     = 5'd17;
  localparam logic [4:0] kSAIL_ALUCTL_REMU    = 5'd18;

  localparam logic [2:0] kBR_NONE = 3'd0;
  localparam logic [2:0] kBR_BEQ  = 3'd1;
  localparam logic [2:0] kBR_BNE  = 3'd2;
  localparam logic [2:0] kBR_BLT  = 3'd3;
  localparam logic [2:0] kBR_BGE  = 3'd4;
  localparam logic [2:0] kBR_BLTU = 3'd5;
  localparam logic [2:0] kBR_BGEU = 3'd6;

  localparam logic [6:0] kOPC_LUI    = 7'b0110111;
  localparam logic [6:0] kOPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] kOPC_JAL    = 7'b1101111;
  localparam logic [6:0] kOPC_JALR   = 7'b1100111;
  localparam logic [6:0] kOPC_BRANCH = 7'b1100011;
  localparam logic [6:0] kOPC_LOAD   = 7'b0000011;
  localparam logic [6:0] kOPC_STORE  = 7'b0100011;
  localparam logic [6:0] kOPC_IMMOP  = 7'b0010011;
  localparam logic [6:0] kOPC_ALUOP  = 7'b0110011;

  localparam logic [6:0] kF7_BASE = 7'b0000000;
  localparam logic [6:0] kF7_ALT  = 7'b0100000;
  localparam logic [6:0] kF7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [kALU_OP_SEL_WIDTH-1:0]     op;
    logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel;
    logic                             illegal;
    logic                             is_muldiv;
  } alu_ctl_t;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'd0:    op = kSAIL_ALUCTL_ADD;
      3'd1:    op = kSAIL_ALUCTL_SLL;
      3'd2:    op = kSAIL_ALUCTL_SLT;
      3'd3:    op = kSAIL_ALUCTL_SLTU;
      3'd4:    op = kSAIL_ALUCTL_XOR;
      3'd5:    op = kSAIL_ALUCTL_SRL;
      3'd6:    op = kSAIL_ALUCTL_OR;
      default: op = kSAIL_ALUCTL_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of opcode/funct3/funct7 into
// ALU op, branch select, illegal flag and mul/div marker.
module alu_ctrl_decode
  import alu_ctrl_stage_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [6:0]                       opcode_i,
  input  logic [2:0]                       funct3_i,
  input  logic [6:0]                       funct7_i,
  output logic [kALU_OP_SEL_WIDTH-1:0]     op_o,
  output logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel_o,
  output logic                             illegal_o,
  output logic                             is_muldiv_o
);

  logic f7_base;
  logic f7_alt;
  logic f7_mul;

  assign f7_base = (funct7_i == kF7_BASE);
  assign f7_alt  = (funct7_i == kF7_ALT);
  assign f7_mul  = (funct7_i == kF7_MUL) && (ENABLE_M != 0);

  always_comb begin
    op_o         = kSAIL_ALUCTL_ILLEGAL;
    branch_sel_o = kBR_NONE;
    illegal_o    = 1'b1;
    is_muldiv_o  = 1'b0;
    unique case (1'b1)
      opcode_i == kOPC_LUI: begin
        op_o      = kSAIL_ALUCTL_AND;
        illegal_o = 1'b0;
      end
      opcode_i == kOPC_AUIPC: begin
        op_o      = kSAIL_ALUCTL_ADD;
        illegal_o = 1'b0;
      end
      (opcode_i == kOPC_JAL) || (opcode_i == kOPC_JALR): begin
        illegal_o = 1'b0;
      end
      opcode_i == kOPC_BRANCH: begin
        illegal_o = 1'b0;
        case (funct3_i)
          3'b000:  branch_sel_o = kBR_BEQ;
          3'b001:  branch_sel_o = kBR_BNE;
          3'b100:  branch_sel_o = kBR_BLT;
          3'b101:  branch_sel_o = kBR_BGE;
          3'b110:  branch_sel_o = kBR_BLTU;
          3'b111:  branch_sel_o = kBR_BGEU;
          default: illegal_o    = 1'b1;
        endcase
      end
      opcode_i == kOPC_LOAD: begin
        if (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          op_o      = kSAIL_ALUCTL_ADD;
          illegal_o = 1'b0;
        end
      end
      opcode_i == kOPC_STORE: begin
        if (funct3_i inside {3'b000, 3'b001, 3'b010}) begin
          op_o      = kSAIL_ALUCTL_ADD;
          illegal_o = 1'b0;
        end
      end
      opcode_i == kOPC_IMMOP: begin
        case (funct3_i)
          3'b001: begin
            if (f7_base) begin
              op_o      = kSAIL_ALUCTL_SLL;
              illegal_o = 1'b0;
            end
          end
          3'b101: begin
            if (f7_base) begin
              op_o      = kSAIL_ALUCTL_SRL;
              illegal_o = 1'b0;
            end else if (f7_alt) begin
              op_o      = kSAIL_ALUCTL_SRA;
              illegal_o = 1'b0;
            end
          end
          default: begin
            op_o      = base_op(funct3_i);
            illegal_o = 1'b0;
          end
        endcase
      end
      opcode_i == kOPC_ALUOP: begin
        if (f7_base) begin
          op_o      = base_op(funct3_i);
          illegal_o = 1'b0;
        end else if (f7_alt && funct3_i == 3'b000) begin
          op_o      = kSAIL_ALUCTL_SUB;
          illegal_o = 1'b0;
        end else if (f7_alt && funct3_i == 3'b101) begin
          op_o      = kSAIL_ALUCTL_SRA;
          illegal_o = 1'b0;
        end else if (f7_mul) begin
          // M codes are contiguous in funct3 order
          op_o        = kSAIL_ALUCTL_MUL + {2'b00, funct3_i};
          illegal_o   = 1'b0;
          is_muldiv_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decode, 2-entry skid FIFO and
// mul/div occupancy counter holding off issue while the ALU is busy.
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
#(
  parameter int ENABLE_M       = 0,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [6:0]                       opcode_i,
  input  logic [2:0]                       funct3_i,
  input  logic [6:0]                       funct7_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [kALU_OP_SEL_WIDTH-1:0]     alu_op_sel_o,
  output logic [kALU_BRANCH_SEL_WIDTH-1:0] alu_branch_sel_o,
  output logic                             illegal_o,
  output logic                             busy_o
);

  localparam int kBusyW =
    (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
  localparam logic [kBusyW-1:0] kBusyLoad =
    kBusyW'(MULDIV_LATENCY - 1);

  logic [kALU_OP_SEL_WIDTH-1:0]     dec_op;
  logic [kALU_BRANCH_SEL_WIDTH-1:0] dec_br;
  logic                             dec_ill;
  logic                             dec_md;
  alu_ctl_t                         dec;

  alu_ctl_t          mem [2];
  alu_ctl_t          head;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [kBusyW-1:0] busy_cnt;
  logic              push;
  logic              pop;

  alu_ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .op_o         (dec_op),
    .branch_sel_o (dec_br),
    .illegal_o    (dec_ill),
    .is_muldiv_o  (dec_md)
  );

  assign dec  = {dec_op, dec_br, dec_ill, dec_md};
  assign head = mem[rd_ptr];

  assign in_ready_o  = (count != 2'd2);
  assign out_valid_o = (count != 2'd0) && (busy_cnt == '0);
  assign busy_o      = (busy_cnt != '0);

  assign alu_op_sel_o     = head.op;
  assign alu_branch_sel_o = head.branch_sel;
  assign illegal_o        = head.illegal;

  assign push = in_valid_i & in_ready_o & ~flush_i & ~reset_i;
  assign pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      busy_cnt <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      if (flush_i) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: ;
        endcase
      end
      // the in-flight op keeps the ALU even across a flush
      if (pop && head.is_muldiv) busy_cnt <= kBusyLoad;
      else if (busy_cnt != '0) busy_cnt <= busy_cnt - kBusyW'(1);
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: directed steps then random traffic,
// checked against a queue-based reference model every cycle.
module tb_alu_ctrl_stage;
  import alu_ctrl_stage_pkg::*;

  localparam int LAT = 4;

  typedef struct {
    logic [4:0] op;
    logic [2:0] br;
    logic       ill;
    logic       md;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] op_sel;
  logic [2:0] br_sel;
  logic       ill;
  logic       busy;

  logic       m0_flush;
  logic       m0_in_valid;
  logic       m0_in_ready;
  logic [6:0] m0_opc;
  logic [2:0] m0_f3;
  logic [6:0] m0_f7;
  logic       m0_out_valid;
  logic       m0_out_ready;
  logic [4:0] m0_op;
  logic [2:0] m0_br;
  logic       m0_ill;
  logic       m0_busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   busy_m   = 0;

  alu_ctrl_stage #(
    .ENABLE_M       (1),
    .MULDIV_LATENCY (LAT)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .opcode_i         (opc),
    .funct3_i         (f3),
    .funct7_i         (f7),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .alu_op_sel_o     (op_sel),
    .alu_branch_sel_o (br_sel),
    .illegal_o        (ill),
    .busy_o           (busy)
  );

  alu_ctrl_stage #(
    .ENABLE_M       (0),
    .MULDIV_LATENCY (LAT)
  ) dut_m0 (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (m0_flush),
    .in_valid_i       (m0_in_valid),
    .in_ready_o       (m0_in_ready),
    .opcode_i         (m0_opc),
    .funct3_i         (m0_f3),
    .funct7_i         (m0_f7),
    .out_valid_o      (m0_out_valid),
    .out_ready_i      (m0_out_ready),
    .alu_op_sel_o     (m0_op),
    .alu_branch_sel_o (m0_br),
    .illegal_o        (m0_ill),
    .busy_o           (m0_busy)
  );

  function automatic exp_t ref_dec(input logic [6:0] o,
                                   input logic [2:0] f,
                                   input logic [6:0] s,
                                   input bit en_m);
    logic [4:0] alu_tbl [8];
    logic [4:0] mul_tbl [8];
    logic [2:0] br_tbl  [8];
    exp_t e;
    alu_tbl = '{kSAIL_ALUCTL_ADD, kSAIL_ALUCTL_SLL, kSAIL_ALUCTL_SLT,
                kSAIL_ALUCTL_SLTU, kSAIL_ALUCTL_XOR, kSAIL_ALUCTL_SRL,
                kSAIL_ALUCTL_OR, kSAIL_ALUCTL_AND};
    mul_tbl = '{kSAIL_ALUCTL_MUL, kSAIL_ALUCTL_MULH,
                kSAIL_ALUCTL_MULHSU, kSAIL_ALUCTL_MULHU,
                kSAIL_ALUCTL_DIV, kSAIL_ALUCTL_DIVU,
                kSAIL_ALUCTL_REM, kSAIL_ALUCTL_REMU};
    br_tbl  = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
    e = '{op: kSAIL_ALUCTL_ILLEGAL, br: 3'd0, ill: 1'b0, md: 1'b0};
    case (o)
      kOPC_LUI:   e.op = kSAIL_ALUCTL_AND;
      kOPC_AUIPC: e.op = kSAIL_ALUCTL_ADD;
      kOPC_JAL, kOPC_JALR: ;
      kOPC_BRANCH: begin
        if (br_tbl[f] != 3'd0) e.br = br_tbl[f];
        else e.ill = 1'b1;
      end
      kOPC_LOAD: begin
        if (f == 3'd3 || f > 3'd5) e.ill = 1'b1;
        else e.op = kSAIL_ALUCTL_ADD;
      end
      kOPC_STORE: begin
        if (f > 3'd2) e.ill = 1'b1;
        else e.op = kSAIL_ALUCTL_ADD;
      end
      kOPC_IMMOP: begin
        if (f == 3'd1 && s != 7'h00) e.ill = 1'b1;
        else if (f == 3'd5 && s != 7'h00 && s != 7'h20) e.ill = 1'b1;
        else if (f == 3'd5 && s == 7'h20) e.op = kSAIL_ALUCTL_SRA;
        else e.op = alu_tbl[f];
      end
      kOPC_ALUOP: begin
        if (s == 7'h00) e.op = alu_tbl[f];
        else if (s == 7'h20 && f == 3'd0) e.op = kSAIL_ALUCTL_SUB;
        else if (s == 7'h20 && f == 3'd5) e.op = kSAIL_ALUCTL_SRA;
        else if (s == 7'h01 && en_m) begin
          e.op = mul_tbl[f];
          e.md = 1'b1;
        end else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.op = kSAIL_ALUCTL_ILLEGAL;
      e.br = 3'd0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t d;
    bit   do_pop;
    bit   do_push;
    d       = ref_dec(opc, f3, f7, 1'b1);
    do_pop  = (q.size() != 0) && (busy_m == 0) && out_ready;
    do_push = in_valid && (q.size() != 2) && !flush;
    @(posedge clk);
    if (reset_i) begin
      q.delete();
      busy_m = 0;
    end else begin
      if (do_pop) begin
        busy_m = q[0].md ? LAT - 1 : 0;
        void'(q.pop_front());
      end else if (busy_m > 0) begin
        busy_m--;
      end
      if (flush) q.delete();
      else if (do_push) q.push_back(d);
    end
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0 && busy_m == 0));
    chk("busy", 32'(busy), 32'(busy_m != 0));
    if (q.size() != 0) begin
      chk("head_op", 32'(op_sel), 32'(q[0].op));
      chk("head_br", 32'(br_sel), 32'(q[0].br));
      chk("head_ill", 32'(ill), 32'(q[0].ill));
    end
  endtask

  task automatic set_in(input logic v, input logic [6:0] o,
                        input logic [2:0] f, input logic [6:0] s);
    in_valid = v;
    opc      = o;
    f3       = f;
    f7       = s;
  endtask

  task automatic m0_issue(input string tag, input logic [6:0] o,
                          input logic [2:0] f, input logic [6:0] s,
                          input logic [4:0] exp_op, input logic exp_ill);
    m0_in_valid = 1'b1;
    m0_opc      = o;
    m0_f3       = f;
    m0_f7       = s;
    step();
    m0_in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(m0_out_valid), 32'd1);
    chk({tag, "_op"}, 32'(m0_op), 32'(exp_op));
    chk({tag, "_ill"}, 32'(m0_ill), 32'(exp_ill));
    step();
    chk({tag, "_drained"}, 32'(m0_out_valid), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_op"}, 32'(op_sel), 32'd0);
    chk({tag, "_br"}, 32'(br_sel), 32'd0);
    chk({tag, "_ill"}, 32'(ill), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [6:0] opc_pool [9];

  initial begin
    opc_pool = '{kOPC_LUI, kOPC_AUIPC, kOPC_JAL, kOPC_JALR, kOPC_BRANCH,
                 kOPC_LOAD, kOPC_STORE, kOPC_IMMOP, kOPC_ALUOP};
    reset_i      = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b0;
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    m0_flush     = 1'b0;
    m0_in_valid  = 1'b0;
    m0_opc       = 7'd0;
    m0_f3        = 3'd0;
    m0_f7        = 7'd0;
    m0_out_ready = 1'b1;

    // reset state, with a push attempt held during reset
    @(negedge clk);
    step();
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h00);
    step();
    chk_zero_outputs("reset");
    chk("m0_reset_valid", 32'(m0_out_valid), 32'd0);
    reset_i = 1'b0;
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    step();

    // decode sweep on the ENABLE_M=0 instance
    m0_issue("m0_sub", kOPC_ALUOP, 3'd0, 7'h20, kSAIL_ALUCTL_SUB, 1'b0);
    m0_issue("m0_sltiu", kOPC_IMMOP, 3'd3, 7'h55, kSAIL_ALUCTL_SLTU, 1'b0);
    m0_issue("m0_mul", kOPC_ALUOP, 3'd0, 7'h01, kSAIL_ALUCTL_ILLEGAL, 1'b1);
    chk("m0_busy", 32'(m0_busy), 32'd0);

    // DIV then ADD: DIV occupies the ALU for LAT cycles
    out_ready = 1'b1;
    set_in(1'b1, kOPC_ALUOP, 3'd4, 7'h01);
    step();
    chk("div_head", 32'(op_sel), 32'(kSAIL_ALUCTL_DIV));
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h00);
    step();
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    for (int i = 0; i < LAT - 1; i++) begin
      chk("div_stall_valid", 32'(out_valid), 32'd0);
      chk("div_stall_busy", 32'(busy), 32'd1);
      step();
    end
    chk("after_div_valid", 32'(out_valid), 32'd1);
    chk("after_div_op", 32'(op_sel), 32'(kSAIL_ALUCTL_ADD));
    step();
    chk("after_add_valid", 32'(out_valid), 32'd0);

    // backpressure and FIFO order
    out_ready = 1'b0;
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h00);
    step();
    set_in(1'b1, kOPC_ALUOP, 3'd4, 7'h00);
    step();
    chk("bp_full", 32'(in_ready), 32'd0);
    set_in(1'b1, kOPC_ALUOP, 3'd6, 7'h00);
    step();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_head0", 32'(op_sel), 32'(kSAIL_ALUCTL_ADD));
    out_ready = 1'b1;
    step();
    chk("bp_head1", 32'(op_sel), 32'(kSAIL_ALUCTL_XOR));
    chk("bp_reopen", 32'(in_ready), 32'd1);
    step();
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    chk("bp_head2", 32'(op_sel), 32'(kSAIL_ALUCTL_OR));
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // illegal encodings at full throughput
    set_in(1'b1, kOPC_BRANCH, 3'd2, 7'h00);
    step();
    chk("ill_br_flag", 32'(ill), 32'd1);
    chk("ill_br_bsel", 32'(br_sel), 32'd0);
    set_in(1'b1, kOPC_STORE, 3'd3, 7'h00);
    step();
    chk("ill_st_op", 32'(op_sel), 32'(kSAIL_ALUCTL_ILLEGAL));
    set_in(1'b1, kOPC_IMMOP, 3'd1, 7'h20);
    step();
    chk("ill_slli_flag", 32'(ill), 32'd1);
    set_in(1'b1, kOPC_BRANCH, 3'd7, 7'h00);
    step();
    chk("bgeu_bsel", 32'(br_sel), 32'(kBR_BGEU));
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    step();

    // flush with count=2 and with count=1, each with a push attempt
    out_ready = 1'b0;
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h00);
    step();
    step();
    flush = 1'b1;
    set_in(1'b1, kOPC_ALUOP, 3'd6, 7'h00);
    step();
    flush = 1'b0;
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    chk("flush2_valid", 32'(out_valid), 32'd0);
    chk("flush2_ready", 32'(in_ready), 32'd1);
    step();
    chk("flush2_stays", 32'(out_valid), 32'd0);
    set_in(1'b1, kOPC_ALUOP, 3'd4, 7'h00);
    step();
    flush = 1'b1;
    set_in(1'b1, kOPC_ALUOP, 3'd6, 7'h00);
    step();
    flush = 1'b0;
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    chk("flush1_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush1_stays", 32'(out_valid), 32'd0);

    // flush during a mul stall leaves the counter running
    out_ready = 1'b1;
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h01);
    step();
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h00);
    step();
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_stall_busy1", 32'(busy), 32'd1);
    step();
    chk("flush_stall_busy2", 32'(busy), 32'd1);
    step();
    chk("flush_stall_done", 32'(busy), 32'd0);
    chk("flush_stall_empty", 32'(out_valid), 32'd0);

    // reset mid-stall with one entry queued
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h01);
    step();
    set_in(1'b1, kOPC_ALUOP, 3'd4, 7'h00);
    step();
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk_zero_outputs("mid_reset");
    set_in(1'b1, kOPC_ALUOP, 3'd0, 7'h00);
    step();
    set_in(1'b0, 7'd0, 3'd0, 7'd0);
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    chk("post_reset_op", 32'(op_sel), 32'(kSAIL_ALUCTL_ADD));
    step();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] r_opc;
      logic [6:0] r_f7;
      int         sel;
      sel   = int'($urandom_range(0, 9));
      r_opc = (sel == 9) ? 7'($urandom) : opc_pool[sel];
      case ($urandom_range(0, 3))
        0:       r_f7 = 7'h00;
        1:       r_f7 = 7'h20;
        2:       r_f7 = 7'h01;
        default: r_f7 = 7'($urandom);
      endcase
      set_in($urandom_range(0, 3) != 0, r_opc, 3'($urandom), r_f7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      reset_i   = ($urandom_range(0, 199) == 0);
      step();
    end
    reset_i = 1'b0;
    flush   = 1'b0;
    set_in(1'b0, 7'd0, 3'd0, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
